// File: rtl/ide_sector_fetch.sv
// IDE sector fetch engine: pulls 512-byte sectors from a byte-wide backing store
// and packs them into 16-bit words for the host-side sector RAM.
module ide_sector_fetch #(
    parameter logic [27:0] MAX_LBA     = 28'h0FFFFFF,
    parameter logic [15:0] ACK_TIMEOUT = 16'd65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd,
    input  logic [27:0] lba,
    input  logic [7:0]  count,
    input  logic        host_done,
    output logic        mem_req,
    output logic [36:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        ram_we,
    output logic [7:0]  ram_waddr,
    output logic [15:0] ram_wdata,
    output logic        bsy,
    output logic        drq,
    output logic        irq,
    output logic [7:0]  err_code
);

    typedef enum logic [1:0] {IDLE, FILL, WAIT_HOST, ERROR} state_t;

    state_t      state, state_next;
    // One extra bit so stepping past the last sector cannot wrap back to zero.
    logic [28:0] cur_lba;
    logic [8:0]  remaining;
    logic [8:0]  byte_cnt;
    logic [7:0]  low_byte;
    logic [15:0] idle_cnt;

    logic cmd_ok, take_cmd, lba_bad, timed_out, last_byte, more;

    assign cmd_ok    = (cmd == 8'h20) || (cmd == 8'h21);
    assign take_cmd  = cmd_valid && (state != FILL);
    assign lba_bad   = cur_lba > {1'b0, MAX_LBA};
    assign timed_out = !mem_ack && (idle_cnt >= ACK_TIMEOUT - 16'd1);
    assign last_byte = mem_ack && (byte_cnt == 9'd511);
    assign more      = remaining != 9'd1;

    assign mem_req  = (state == FILL) && !lba_bad;
    assign mem_addr = {cur_lba[27:0], 9'b0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cmd_valid) state_next = cmd_ok ? FILL : ERROR;
            end
            FILL: begin
                if (lba_bad || timed_out) state_next = ERROR;
                else if (last_byte)       state_next = WAIT_HOST;
            end
            WAIT_HOST: begin
                if (cmd_valid)      state_next = cmd_ok ? FILL : ERROR;
                else if (host_done) state_next = more ? FILL : IDLE;
            end
            ERROR: begin
                if (cmd_valid)      state_next = cmd_ok ? FILL : ERROR;
                else if (host_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_lba   <= '0;
            remaining <= '0;
            byte_cnt  <= '0;
            low_byte  <= '0;
            idle_cnt  <= '0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            bsy       <= 1'b0;
            drq       <= 1'b0;
            irq       <= 1'b0;
            err_code  <= '0;
        end else begin
            ram_we <= 1'b0;
            if (take_cmd) begin
                drq <= 1'b0;
                if (cmd_ok) begin
                    cur_lba   <= {1'b0, lba};
                    remaining <= (count == 8'd0) ? 9'd256 : {1'b0, count};
                    bsy       <= 1'b1;
                    irq       <= 1'b0;
                    err_code  <= '0;
                    byte_cnt  <= '0;
                    idle_cnt  <= '0;
                    ram_waddr <= '0;
                end else begin
                    bsy      <= 1'b0;
                    irq      <= 1'b1;
                    err_code <= 8'h04;
                end
            end else begin
                unique case (state)
                    FILL: begin
                        if (lba_bad) begin
                            bsy      <= 1'b0;
                            irq      <= 1'b1;
                            err_code <= 8'h10;
                        end else if (timed_out) begin
                            bsy      <= 1'b0;
                            irq      <= 1'b1;
                            err_code <= 8'h40;
                        end else if (mem_ack) begin
                            idle_cnt <= '0;
                            byte_cnt <= byte_cnt + 9'd1;
                            if (!byte_cnt[0]) begin
                                low_byte <= mem_data;
                            end else begin
                                ram_we    <= 1'b1;
                                ram_wdata <= {mem_data, low_byte};
                                ram_waddr <= byte_cnt[8:1];
                            end
                            if (last_byte) begin
                                bsy <= 1'b0;
                                drq <= 1'b1;
                                irq <= 1'b1;
                            end
                        end else begin
                            idle_cnt <= idle_cnt + 16'd1;
                        end
                    end
                    WAIT_HOST: begin
                        if (host_done) begin
                            drq       <= 1'b0;
                            irq       <= 1'b0;
                            remaining <= remaining - 9'd1;
                            if (more) begin
                                cur_lba   <= cur_lba + 29'd1;
                                bsy       <= 1'b1;
                                byte_cnt  <= '0;
                                idle_cnt  <= '0;
                                ram_waddr <= '0;
                            end
                        end
                    end
                    ERROR: begin
                        if (host_done) irq <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ide_sector_fetch.sv
// Directed self-checking bench for ide_sector_fetch: single/multi-sector reads,
// command abort, ack timeout, LBA range error and asynchronous reset mid-burst.
module tb_ide_sector_fetch;

    localparam logic [27:0] TB_MAX_LBA = 28'h0FFFFFF;
    localparam int          TB_TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic [27:0] lba;
    logic [7:0]  count;
    logic        host_done;
    logic        mem_req;
    logic [36:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        ram_we;
    logic [7:0]  ram_waddr;
    logic [15:0] ram_wdata;
    logic        bsy, drq, irq;
    logic [7:0]  err_code;

    int tests_run    = 0;
    int tests_failed = 0;

    ide_sector_fetch #(.MAX_LBA(TB_MAX_LBA), .ACK_TIMEOUT(16'(TB_TIMEOUT))) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd(cmd), .lba(lba),
        .count(count), .host_done(host_done), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .ram_we(ram_we), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .bsy(bsy), .drq(drq), .irq(irq), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic issue_cmd(input logic [7:0] c, input logic [27:0] l, input logic [7:0] n);
        @(negedge clk);
        cmd_valid = 1'b1; cmd = c; lba = l; count = n;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_host_done();
        @(negedge clk);
        host_done = 1'b1;
        @(negedge clk);
        host_done = 1'b0;
    endtask

    // Byte i carries value i mod 256; every odd byte must surface as a word write one cycle later.
    task automatic feed_bytes(input logic [36:0] exp_addr, input int n, output int bad);
        logic [7:0] lo, hi, widx;
        bad = 0;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i < n && (mem_req !== 1'b1 || mem_addr !== exp_addr)) bad++;
            if (i > 0 && ((i - 1) % 2) == 1) begin
                lo = 8'(i - 2); hi = 8'(i - 1); widx = 8'((i - 1) / 2);
                if (ram_we !== 1'b1 || ram_wdata !== {hi, lo} || ram_waddr !== widx) bad++;
            end else if (ram_we !== 1'b0) begin
                bad++;
            end
            if (i < n) begin
                mem_ack = 1'b1; mem_data = 8'(i);
            end else begin
                mem_ack = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bsy, drq, irq, mem_req, ram_we} !== 5'b0) begin
            tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 00000", {bsy, drq, irq, mem_req, ram_we});
        end
        tests_run++;
        if (ram_waddr !== 8'h00 || err_code !== 8'h00 || mem_addr !== 37'h0) begin
            tests_failed++; $display("[TB] FAIL reset_regs: got waddr=%h err=%h addr=%h expected all 0", ram_waddr, err_code, mem_addr);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        int bad;
        issue_cmd(8'h20, 28'd5, 8'd1);
        tests_run++;
        if (bsy !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 37'hA00) begin
            tests_failed++; $display("[TB] FAIL single_start: got bsy=%b req=%b addr=%h expected 1 1 a00", bsy, mem_req, mem_addr);
        end
        issue_cmd(8'hEC, 28'd0, 8'd1);
        tests_run++;
        if (bsy !== 1'b1 || irq !== 1'b0 || err_code !== 8'h00) begin
            tests_failed++; $display("[TB] FAIL cmd_while_busy: got bsy=%b irq=%b err=%h expected 1 0 00", bsy, irq, err_code);
        end
        feed_bytes(37'hA00, 512, bad);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++; $display("[TB] FAIL single_burst: got %0d bad cycles expected 0", bad);
        end
        tests_run++;
        if ({mem_req, bsy, drq, irq} !== 4'b0011) begin
            tests_failed++; $display("[TB] FAIL single_done: got req,bsy,drq,irq=%b expected 0011", {mem_req, bsy, drq, irq});
        end
        @(negedge clk); mem_ack = 1'b1; mem_data = 8'h11;
        @(negedge clk); mem_data = 8'h22;
        @(negedge clk); mem_ack = 1'b0;
        tests_run++;
        if (ram_we !== 1'b0 || drq !== 1'b1 || mem_req !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL ack_outside_fill: got we=%b drq=%b req=%b expected 0 1 0", ram_we, drq, mem_req);
        end
        pulse_host_done();
        tests_run++;
        if ({mem_req, bsy, drq, irq} !== 4'b0000) begin
            tests_failed++; $display("[TB] FAIL single_host_done: got req,bsy,drq,irq=%b expected 0000", {mem_req, bsy, drq, irq});
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        issue_cmd(8'h21, 28'd7, 8'd2);
        feed_bytes(37'hE00, 512, bad);
        tests_run++;
        if (bad !== 0 || drq !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL b2b_first: got bad=%0d drq=%b expected 0 1", bad, drq);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b0 || bsy !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL b2b_hold: got req=%b bsy=%b expected 0 0", mem_req, bsy);
        end
        pulse_host_done();
        tests_run++;
        if (bsy !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 37'h1000 || drq !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL b2b_second_start: got bsy=%b req=%b addr=%h drq=%b expected 1 1 1000 0", bsy, mem_req, mem_addr, drq);
        end
        feed_bytes(37'h1000, 512, bad);
        tests_run++;
        if (bad !== 0 || drq !== 1'b1 || bsy !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL b2b_second: got bad=%0d drq=%b bsy=%b expected 0 1 0", bad, drq, bsy);
        end
        pulse_host_done();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({mem_req, bsy, drq, irq} !== 4'b0000) begin
            tests_failed++; $display("[TB] FAIL b2b_idle: got req,bsy,drq,irq=%b expected 0000", {mem_req, bsy, drq, irq});
        end
    endtask

    task automatic test_abort();
        issue_cmd(8'hEC, 28'd5, 8'd1);
        tests_run++;
        if (err_code !== 8'h04 || irq !== 1'b1 || bsy !== 1'b0 || mem_req !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL abort: got err=%h irq=%b bsy=%b req=%b expected 04 1 0 0", err_code, irq, bsy, mem_req);
        end
        pulse_host_done();
        tests_run++;
        if (err_code !== 8'h04 || irq !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL abort_clear: got err=%h irq=%b expected 04 0", err_code, irq);
        end
        issue_cmd(8'h20, 28'd2, 8'd1);
        tests_run++;
        if (err_code !== 8'h00 || bsy !== 1'b1 || mem_addr !== 37'h400) begin
            tests_failed++; $display("[TB] FAIL accept_clears_err: got err=%h bsy=%b addr=%h expected 00 1 400", err_code, bsy, mem_addr);
        end
    endtask

    // Continues from the sector accepted at the end of test_abort.
    task automatic test_timeout();
        int bad, waited;
        feed_bytes(37'h400, 100, bad);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++; $display("[TB] FAIL timeout_prefix: got %0d bad cycles expected 0", bad);
        end
        waited = 0;
        while (irq !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (waited !== TB_TIMEOUT) begin
            tests_failed++; $display("[TB] FAIL timeout_cycles: got %0d expected %0d", waited, TB_TIMEOUT);
        end
        tests_run++;
        if (err_code !== 8'h40 || mem_req !== 1'b0 || bsy !== 1'b0 || irq !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL timeout_status: got err=%h req=%b bsy=%b irq=%b expected 40 0 0 1", err_code, mem_req, bsy, irq);
        end
        pulse_host_done();
    endtask

    task automatic test_max_lba();
        int bad;
        issue_cmd(8'h20, TB_MAX_LBA, 8'd2);
        feed_bytes(37'h1FFFFFE00, 512, bad);
        tests_run++;
        if (bad !== 0 || drq !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL max_lba_first: got bad=%0d drq=%b expected 0 1", bad, drq);
        end
        pulse_host_done();
        tests_run++;
        if (mem_req !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL max_lba_no_req: got req=%b expected 0", mem_req);
        end
        @(negedge clk);
        tests_run++;
        if (err_code !== 8'h10 || irq !== 1'b1 || mem_req !== 1'b0 || bsy !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL max_lba_idnf: got err=%h irq=%b req=%b bsy=%b expected 10 1 0 0", err_code, irq, mem_req, bsy);
        end
        pulse_host_done();
    endtask

    task automatic test_reset_mid_burst();
        int bad;
        issue_cmd(8'h20, 28'd0, 8'd0);
        feed_bytes(37'h0, 512, bad);
        pulse_host_done();
        tests_run++;
        if (bad !== 0 || bsy !== 1'b1 || mem_addr !== 37'h200) begin
            tests_failed++; $display("[TB] FAIL count0_continue: got bad=%0d bsy=%b addr=%h expected 0 1 200", bad, bsy, mem_addr);
        end
        feed_bytes(37'h200, 300, bad);
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({bsy, drq, irq, mem_req, ram_we} !== 5'b0 || ram_waddr !== 8'h00 || err_code !== 8'h00 || mem_addr !== 37'h0) begin
            tests_failed++; $display("[TB] FAIL async_reset: got flags=%b waddr=%h err=%h addr=%h expected 0", {bsy, drq, irq, mem_req, ram_we}, ram_waddr, err_code, mem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        issue_cmd(8'h20, 28'd3, 8'd1);
        tests_run++;
        if (bsy !== 1'b1 || mem_addr !== 37'h600) begin
            tests_failed++; $display("[TB] FAIL post_reset_accept: got bsy=%b addr=%h expected 1 600", bsy, mem_addr);
        end
        feed_bytes(37'h600, 512, bad);
        tests_run++;
        if (bad !== 0 || drq !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL post_reset_burst: got bad=%0d drq=%b expected 0 1", bad, drq);
        end
        issue_cmd(8'h20, 28'd9, 8'd1);
        tests_run++;
        if (drq !== 1'b0 || irq !== 1'b0 || bsy !== 1'b1 || mem_addr !== 37'h1200) begin
            tests_failed++; $display("[TB] FAIL cmd_in_wait_host: got drq=%b irq=%b bsy=%b addr=%h expected 0 0 1 1200", drq, irq, bsy, mem_addr);
        end
        feed_bytes(37'h1200, 512, bad);
        pulse_host_done();
        tests_run++;
        if (bad !== 0 || {mem_req, bsy, drq, irq} !== 4'b0000) begin
            tests_failed++; $display("[TB] FAIL restart_done: got bad=%0d req,bsy,drq,irq=%b expected 0 0000", bad, {mem_req, bsy, drq, irq});
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd = '0; lba = '0; count = '0;
        host_done = 1'b0; mem_ack = 1'b0; mem_data = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_timeout();
        test_max_lba();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
